// File: rtl/audio_mixer.sv
// Time-multiplexed stereo mixer: one source per clock through a shared multiplier
// pair, master gain and saturation on the final cycle, sticky clip/overrun flags.
module audio_mixer #(
    parameter int NUM_SRC = 4,
    parameter int IN_W    = 16,
    parameter int OUT_W   = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     next_sample,
    input  logic [NUM_SRC*IN_W-1:0]  src_left,
    input  logic [NUM_SRC*IN_W-1:0]  src_right,
    input  logic [NUM_SRC*4-1:0]     src_volume,
    input  logic [NUM_SRC-1:0]       src_mute,
    input  logic [3:0]               master_volume,
    input  logic                     clip_clear,
    output logic [OUT_W-1:0]         left_data,
    output logic [OUT_W-1:0]         right_data,
    output logic                     data_valid,
    output logic                     busy,
    output logic                     clip_left,
    output logic                     clip_right,
    output logic                     overrun
);

    localparam int CNT_W = $clog2(NUM_SRC);
    localparam int IDX_W = (NUM_SRC > 1) ? CNT_W : 1;
    localparam int ACC_W = IN_W + 1 + CNT_W + 1;
    localparam int MUL_W = ACC_W + 6;

    localparam logic signed [MUL_W-1:0] SAT_MAX = {{(MUL_W-IN_W+1){1'b0}}, {(IN_W-1){1'b1}}};
    localparam logic signed [MUL_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, ACCUM, FINAL} state_t;

    state_t                     state;
    logic [IDX_W-1:0]           idx;
    logic signed [ACC_W-1:0]    acc_l, acc_r;
    logic [NUM_SRC*IN_W-1:0]    snap_left, snap_right;
    logic [NUM_SRC*4-1:0]       snap_vol;
    logic [NUM_SRC-1:0]         snap_mute;
    logic [3:0]                 snap_master;

    logic signed [IN_W-1:0]     cur_l, cur_r;
    logic [4:0]                 src_gain, master_gain;
    logic signed [MUL_W-1:0]    prod_l, prod_r, mix_l, mix_r;
    logic signed [ACC_W-1:0]    acc_l_next, acc_r_next;
    logic                       sat_hit_l, sat_hit_r;
    logic [IN_W-1:0]            sat_l, sat_r;

    // Volume code 15 is unity (16/16); codes 0..14 scale by code/16.
    function automatic logic [4:0] gain_of(input logic [3:0] vol, input logic mute);
        if (mute)
            return 5'd0;
        return (vol == 4'd15) ? 5'd16 : {1'b0, vol};
    endfunction

    // NOTE: every signal driven here gets a value before any branch, so no latch is inferred.
    always_comb begin
        cur_l       = snap_left[idx*IN_W +: IN_W];
        cur_r       = snap_right[idx*IN_W +: IN_W];
        src_gain    = gain_of(snap_vol[idx*4 +: 4], snap_mute[idx]);
        master_gain = gain_of(snap_master, 1'b0);

        prod_l     = MUL_W'(cur_l) * MUL_W'($signed({1'b0, src_gain}));
        prod_r     = MUL_W'(cur_r) * MUL_W'($signed({1'b0, src_gain}));
        acc_l_next = ACC_W'(MUL_W'(acc_l) + (prod_l >>> 4));
        acc_r_next = ACC_W'(MUL_W'(acc_r) + (prod_r >>> 4));

        mix_l = (MUL_W'(acc_l) * MUL_W'($signed({1'b0, master_gain}))) >>> 4;
        mix_r = (MUL_W'(acc_r) * MUL_W'($signed({1'b0, master_gain}))) >>> 4;

        sat_hit_l = (mix_l > SAT_MAX) || (mix_l < SAT_MIN);
        sat_hit_r = (mix_r > SAT_MAX) || (mix_r < SAT_MIN);
        sat_l = (mix_l > SAT_MAX) ? SAT_MAX[IN_W-1:0] :
                (mix_l < SAT_MIN) ? SAT_MIN[IN_W-1:0] : mix_l[IN_W-1:0];
        sat_r = (mix_r > SAT_MAX) ? SAT_MAX[IN_W-1:0] :
                (mix_r < SAT_MIN) ? SAT_MIN[IN_W-1:0] : mix_r[IN_W-1:0];
    end

    // NOTE: the snapshot is pure datapath, always loaded before use, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && next_sample) begin
            snap_left   <= src_left;
            snap_right  <= src_right;
            snap_vol    <= src_volume;
            snap_mute   <= src_mute;
            snap_master <= master_volume;
        end
    end

    // NOTE: non-blocking assignments let each register see pre-edge values; later writes win.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            acc_l      <= '0;
            acc_r      <= '0;
            left_data  <= '0;
            right_data <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            clip_left  <= 1'b0;
            clip_right <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (clip_clear) begin
                clip_left  <= 1'b0;
                clip_right <= 1'b0;
                overrun    <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (next_sample) begin
                        acc_l <= '0;
                        acc_r <= '0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc_l <= acc_l_next;
                    acc_r <= acc_r_next;
                    if (idx == IDX_W'(NUM_SRC - 1))
                        state <= FINAL;
                    else
                        idx <= idx + IDX_W'(1);
                end
                FINAL: begin
                    left_data  <= OUT_W'(sat_l) << (OUT_W - IN_W);
                    right_data <= OUT_W'(sat_r) << (OUT_W - IN_W);
                    if (sat_hit_l)
                        clip_left <= 1'b1;
                    if (sat_hit_r)
                        clip_right <= 1'b1;
                    data_valid <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (next_sample && state != IDLE)
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_audio_mixer.sv
// Directed bench for audio_mixer: vector table of single mixes plus hand-written
// sequences for clip_clear collision, overrun and mid-mix reset.
module tb_audio_mixer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         next_sample = 1'b0;
    logic [63:0]  src_left = '0;
    logic [63:0]  src_right = '0;
    logic [15:0]  src_volume = '0;
    logic [3:0]   src_mute = '0;
    logic [3:0]   master_volume = '0;
    logic         clip_clear = 1'b0;
    logic [23:0]  left_data, right_data;
    logic         data_valid, busy, clip_left, clip_right, overrun;

    int checks = 0;
    int errors = 0;

    audio_mixer #(.NUM_SRC(4), .IN_W(16), .OUT_W(24)) dut (
        .clk           (clk),
        .rst           (rst),
        .next_sample   (next_sample),
        .src_left      (src_left),
        .src_right     (src_right),
        .src_volume    (src_volume),
        .src_mute      (src_mute),
        .master_volume (master_volume),
        .clip_clear    (clip_clear),
        .left_data     (left_data),
        .right_data    (right_data),
        .data_valid    (data_valid),
        .busy          (busy),
        .clip_left     (clip_left),
        .clip_right    (clip_right),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] l;
        logic [63:0] r;
        logic [15:0] vol;
        logic [3:0]  mute;
        logic [3:0]  mvol;
        logic [23:0] el;
        logic [23:0] er;
        logic        ecl;
        logic        ecr;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        src_left      = v.l;
        src_right     = v.r;
        src_volume    = v.vol;
        src_mute      = v.mute;
        master_volume = v.mvol;
    endtask

    task automatic pulse_clear();
        clip_clear = 1'b1;
        tick();
        clip_clear = 1'b0;
    endtask

    // One mix with inputs scrambled right after the strobe; watches a 10-cycle window.
    task automatic run_mix(input vec_t v);
        int dv_n, dv_at, busy_n;
        logic [23:0] got_l, got_r;
        logic got_cl, got_cr;
        dv_n = 0; dv_at = 0; busy_n = 0;
        got_l = '0; got_r = '0; got_cl = 1'b0; got_cr = 1'b0;
        apply(v);
        pulse_clear();
        next_sample = 1'b1;
        tick();
        next_sample   = 1'b0;
        src_left      = ~v.l;
        src_right     = ~v.r;
        src_volume    = ~v.vol;
        src_mute      = ~v.mute;
        master_volume = ~v.mvol;
        for (int c = 1; c <= 10; c++) begin
            if (busy) busy_n++;
            if (data_valid) begin
                dv_n++;
                dv_at  = c;
                got_l  = left_data;
                got_r  = right_data;
                got_cl = clip_left;
                got_cr = clip_right;
            end
            tick();
        end
        check({v.name, " dv_count"}, dv_n, 1);
        check({v.name, " dv_latency"}, dv_at, 6);
        check({v.name, " busy_cycles"}, busy_n, 5);
        check({v.name, " left"}, got_l, v.el);
        check({v.name, " right"}, got_r, v.er);
        check({v.name, " clip_left"}, got_cl, v.ecl);
        check({v.name, " clip_right"}, got_cr, v.ecr);
        check({v.name, " overrun"}, overrun, 1'b0);
    endtask

    initial begin
        int dv_n, dv_first, dv_second;

        vecs[0] = '{name:"unity", l:64'h0000_0000_0000_1000, r:64'h0000_0000_0000_F000,
                    vol:16'h000F, mute:4'b1110, mvol:4'd15, el:24'h100000, er:24'hF00000, ecl:0, ecr:0};
        vecs[1] = '{name:"vol8", l:64'h0000_0000_0000_4000, r:64'h0,
                    vol:16'h0008, mute:4'b1110, mvol:4'd15, el:24'h200000, er:24'h000000, ecl:0, ecr:0};
        vecs[2] = '{name:"vol8_mst8", l:64'h0000_0000_0000_4000, r:64'h0,
                    vol:16'h0008, mute:4'b1110, mvol:4'd8, el:24'h100000, er:24'h000000, ecl:0, ecr:0};
        vecs[3] = '{name:"pos_sat", l:64'h7000_7000_7000_7000, r:64'h0,
                    vol:16'hFFFF, mute:4'b0000, mvol:4'd15, el:24'h7FFF00, er:24'h000000, ecl:1, ecr:0};
        vecs[4] = '{name:"neg_sat", l:64'h9000_9000_9000_9000, r:64'h0,
                    vol:16'hFFFF, mute:4'b0000, mvol:4'd15, el:24'h800000, er:24'h000000, ecl:1, ecr:0};
        vecs[5] = '{name:"floor", l:64'h0000_0000_0000_FFFF, r:64'h0000_0000_0000_0001,
                    vol:16'h0001, mute:4'b1110, mvol:4'd15, el:24'hFFFF00, er:24'h000000, ecl:0, ecr:0};
        vecs[6] = '{name:"mixed", l:64'h0400_0300_0200_0100, r:64'h7FFF_0000_8000_8000,
                    vol:16'hF04F, mute:4'b1000, mvol:4'd14, el:24'h015000, er:24'h800000, ecl:0, ecr:1};
        vecs[7] = '{name:"master0", l:64'h0000_0000_0000_7FFF, r:64'h0000_0000_0000_7FFF,
                    vol:16'h000F, mute:4'b1110, mvol:4'd0, el:24'h000000, er:24'h000000, ecl:0, ecr:0};

        tick();
        tick();
        rst = 1'b0;
        check("reset left", left_data, 0);
        check("reset right", right_data, 0);
        check("reset valid", data_valid, 0);
        check("reset busy", busy, 0);
        check("reset flags", {clip_left, clip_right, overrun}, 0);

        foreach (vecs[i]) run_mix(vecs[i]);

        // clip_clear after a clipping mix clears the flag
        pulse_clear();
        check("clip_clear clears", {clip_left, clip_right}, 0);

        // clip_clear in the FINAL cycle loses against the new clip event
        apply(vecs[3]);
        next_sample = 1'b1;
        tick();
        next_sample = 1'b0;
        repeat (4) tick();
        clip_clear = 1'b1;
        tick();
        clip_clear = 1'b0;
        check("collide valid", data_valid, 1);
        check("collide clip_left", clip_left, 1);

        // Overrun: strobes at T, T+2 (ignored) and T+6 (accepted)
        apply(vecs[0]);
        pulse_clear();
        dv_n = 0; dv_first = 0; dv_second = 0;
        for (int c = 0; c < 14; c++) begin
            next_sample = (c == 0 || c == 2 || c == 6);
            tick();
            next_sample = 1'b0;
            if (data_valid) begin
                dv_n++;
                if (dv_n == 1) dv_first = c + 1;
                else dv_second = c + 1;
                check("overrun left", left_data, 24'h100000);
                check("overrun right", right_data, 24'hF00000);
            end
        end
        check("overrun dv_count", dv_n, 2);
        check("overrun dv_first", dv_first, 6);
        check("overrun dv_second", dv_second, 12);
        check("overrun flag", overrun, 1);

        // Reset at T+3 aborts the mix and clears everything
        next_sample = 1'b1;
        tick();
        next_sample = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset left", left_data, 0);
        check("midreset right", right_data, 0);
        check("midreset valid", data_valid, 0);
        check("midreset busy", busy, 0);
        check("midreset flags", {clip_left, clip_right, overrun}, 0);
        dv_n = 0;
        for (int c = 0; c < 8; c++) begin
            if (data_valid) dv_n++;
            tick();
        end
        check("midreset no dv", dv_n, 0);
        run_mix(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
